// File: rtl/seq_calc_pkg.sv
// Shared constants for the sequential calculator: op codes, FSM state codes,
// display BCD codes and the 7-segment decoder.
package seq_calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_DASH  = 4'hE;

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] bcd);
        case (bcd)
            4'd0:     return 7'b1000000;
            4'd1:     return 7'b1111001;
            4'd2:     return 7'b0100100;
            4'd3:     return 7'b0110000;
            4'd4:     return 7'b0011001;
            4'd5:     return 7'b0010010;
            4'd6:     return 7'b0000010;
            4'd7:     return 7'b1111000;
            4'd8:     return 7'b0000000;
            4'd9:     return 7'b0010000;
            BCD_DASH: return 7'b0111111;
            default:  return 7'b1111111;
        endcase
    endfunction

endpackage

// File: rtl/seq_calc_if.sv
// Request/result bundle between the calculator and its user.
interface seq_calc_if #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned N_SEGS = 8
);
    logic                      start;
    logic signed [WIDTH-1:0]   a;
    logic signed [WIDTH-1:0]   b;
    logic [2:0]                func;
    logic signed [2*WIDTH-1:0] out;
    logic [7*N_SEGS-1:0]       segs;
    logic                      busy;
    logic                      done;
    logic                      err;

    modport master (output start, a, b, func, input out, segs, busy, done, err);
    modport slave (input start, a, b, func, output out, segs, busy, done, err);
endinterface

// File: rtl/seq_muldiv.sv
// Bit-serial magnitude multiplier and, with SEQ_CALC_DIV_EN defined, restoring divider.
// WIDTH iterations, then one cycle where the signed result is presented with valid.
module seq_muldiv
    import seq_calc_pkg::*;
#(
    parameter int unsigned WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [1:0]                op,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic signed [2*WIDTH-1:0] result,
    output logic                      dbz,
    output logic                      valid
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic                 run_q, run_d, neg_q, neg_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d, opa_q, opa_d, mag_r;
    logic [WIDTH-1:0]     opb_q, opb_d, mag_a, mag_b;

    assign mag_a = a[WIDTH-1] ? WIDTH'(-a) : WIDTH'(a);
    assign mag_b = b[WIDTH-1] ? WIDTH'(-b) : WIDTH'(b);
    assign valid = run_q && (cnt_q == LAST);

`ifdef SEQ_CALC_DIV_EN
    logic           div_q, div_d;
    logic [WIDTH:0] rem_sh;

    assign mag_r = div_q ? {{WIDTH{1'b0}}, opb_q} : acc_q;
    assign dbz   = div_q && (opa_q[WIDTH-1:0] == '0);
`else
    logic unused_op;

    assign unused_op = ^op;
    assign mag_r     = acc_q;
    assign dbz       = 1'b0;
`endif

    assign result = dbz ? '0 : (neg_q ? $signed(-mag_r) : $signed(mag_r));

    // Mul: acc += multiplicand (opa) per set multiplier bit (opb).
    // Div: acc holds the partial remainder, opa the divisor, opb dividend -> quotient.
    always_comb begin
        run_d = run_q;
        neg_d = neg_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        opa_d = opa_q;
        opb_d = opb_q;
`ifdef SEQ_CALC_DIV_EN
        div_d  = div_q;
        rem_sh = '0;
`endif
        if (start) begin
            run_d = 1'b1;
            cnt_d = '0;
            acc_d = '0;
            neg_d = a[WIDTH-1] ^ b[WIDTH-1];
            opa_d = {{WIDTH{1'b0}}, mag_a};
            opb_d = mag_b;
`ifdef SEQ_CALC_DIV_EN
            div_d = (op == OP_DIV);
            if (op == OP_DIV) begin
                opa_d = {{WIDTH{1'b0}}, mag_b};
                opb_d = mag_a;
            end
`endif
        end else if (valid) begin
            run_d = 1'b0;
        end else if (run_q) begin
            cnt_d = cnt_q + 1'b1;
`ifdef SEQ_CALC_DIV_EN
            if (div_q) begin
                rem_sh = {acc_q[WIDTH-1:0], opb_q[WIDTH-1]};
                if (rem_sh >= {1'b0, opa_q[WIDTH-1:0]}) begin
                    acc_d = (2*WIDTH)'(rem_sh - {1'b0, opa_q[WIDTH-1:0]});
                    opb_d = {opb_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = (2*WIDTH)'(rem_sh);
                    opb_d = {opb_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                if (opb_q[0]) acc_d = acc_q + opa_q;
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
            end
`else
            if (opb_q[0]) acc_d = acc_q + opa_q;
            opa_d = opa_q << 1;
            opb_d = opb_q >> 1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            neg_q <= 1'b0;
            cnt_q <= '0;
            acc_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
`ifdef SEQ_CALC_DIV_EN
            div_q <= 1'b0;
`endif
        end else begin
            run_q <= run_d;
            neg_q <= neg_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
`ifdef SEQ_CALC_DIV_EN
            div_q <= div_d;
`endif
        end
    end

endmodule

// File: rtl/seq_calc_top.sv
// Sequential add/sub/mul/div calculator with 7-segment display output.
// Division is only built with SEQ_CALC_DIV_EN defined; otherwise op 11 reports an error.
module seq_calc_top
    import seq_calc_pkg::*;
#(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned N_SEGS = 8,
    parameter int unsigned DIGITS = 4
) (
    input logic       clk,
    input logic       rst_n,
    seq_calc_if.slave bus
);
    localparam int unsigned OW = 2 * WIDTH;

    logic [1:0]              state_q, state_d, op_q, op_d;
    logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic signed [OW-1:0]    out_q, out_d, md_result;
    logic                    err_q, err_d, done_q, done_d, fin;
    logic                    accept, md_start, md_dbz, md_valid;
    logic [3:0]              hex [N_SEGS];
    logic [11:0]             a_bcd, b_bcd;
    logic [4*DIGITS+3:0]     r_bcd;
    logic [7*N_SEGS-1:0]     segs;

    function automatic logic [11:0] operand_bcd(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] mag;
        mag = v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
        return {v[WIDTH-1] ? BCD_DASH : BCD_BLANK, 4'(mag / WIDTH'(10)), 4'(mag % WIDTH'(10))};
    endfunction

    function automatic logic [4*DIGITS+3:0] result_bcd(input logic signed [OW-1:0] v);
        logic [OW-1:0]       mag;
        logic [4*DIGITS+3:0] r;
        mag = v[OW-1] ? OW'(-v) : OW'(v);
        r[4*DIGITS +: 4] = v[OW-1] ? BCD_DASH : BCD_BLANK;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(mag % OW'(10));
            mag = mag / OW'(10);
        end
        return r;
    endfunction

    assign accept = bus.start && (state_q != ST_CALC);
`ifdef SEQ_CALC_DIV_EN
    assign md_start = accept && bus.func[1];
`else
    logic unused_dbz;

    assign unused_dbz = md_dbz;
    assign md_start   = accept && (bus.func[1:0] == OP_MUL);
`endif

    seq_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .op     (bus.func[1:0]),
        .a      (bus.a),
        .b      (bus.b),
        .result (md_result),
        .dbz    (md_dbz),
        .valid  (md_valid)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        err_d   = err_q;
        done_d  = 1'b0;
        fin     = 1'b0;
        if (accept) begin
            state_d = ST_CALC;
            op_d    = bus.func[1:0];
            a_d     = bus.a;
            b_d     = bus.b;
            err_d   = 1'b0;
        end else if (state_q == ST_CALC) begin
            case (op_q)
                OP_ADD: begin
                    out_d = OW'(a_q) + OW'(b_q);
                    fin   = 1'b1;
                end
                OP_SUB: begin
                    out_d = OW'(a_q) - OW'(b_q);
                    fin   = 1'b1;
                end
                OP_MUL: begin
                    out_d = md_valid ? md_result : out_q;
                    fin   = md_valid;
                end
                default: begin
`ifdef SEQ_CALC_DIV_EN
                    out_d = md_valid ? md_result : out_q;
                    err_d = md_valid ? md_dbz : err_q;
                    fin   = md_valid;
`else
                    out_d = '0;
                    err_d = 1'b1;
                    fin   = 1'b1;
`endif
                end
            endcase
            if (fin) begin
                state_d = ST_HOLD;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Display: func[2] picks the live operands, otherwise the registered result.
    always_comb begin
        a_bcd = operand_bcd(bus.a);
        b_bcd = operand_bcd(bus.b);
        r_bcd = result_bcd(out_q);
        for (int i = 0; i < N_SEGS; i++) hex[i] = BCD_BLANK;
        if (bus.func[2]) begin
            {hex[6], hex[5], hex[4]} = a_bcd;
            {hex[2], hex[1], hex[0]} = b_bcd;
        end else begin
            for (int i = 0; i <= DIGITS; i++) hex[i] = r_bcd[4*i +: 4];
        end
        for (int i = 0; i < N_SEGS; i++) segs[7*i +: 7] = seg7(hex[i]);
    end

    assign bus.segs = segs;
    assign bus.out  = out_q;
    assign bus.busy = (state_q == ST_CALC);
    assign bus.done = done_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_seq_calc_top.sv
// Self-checking bench for seq_calc_top: vector table, scoreboard, and hand-written
// sequences for ignored starts and mid-operation reset.
module tb_seq_calc_top;
    localparam int W      = 6;
    localparam int NS     = 8;
    localparam int DG     = 4;
    localparam int MD_LAT = W + 1;

    typedef struct {
        int a;
        int b;
        int op;
        int out;
        int err;
        int lat;
    } vec_t;

    typedef struct {
        int out;
        int err;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    vec_t tbl[13];

    always #5 clk = ~clk;

    seq_calc_if #(.WIDTH(W), .N_SEGS(NS)) bus ();

    seq_calc_top #(
        .WIDTH  (W),
        .N_SEGS (NS),
        .DIGITS (DG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            -1:      return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [7*NS-1:0] res_segs(input int v);
        logic [7*NS-1:0] s;
        int m;
        s = '1;
        m = (v < 0) ? -v : v;
        for (int i = 0; i < DG; i++) begin
            s[7*i +: 7] = seg_ref(m % 10);
            m = m / 10;
        end
        s[7*DG +: 7] = seg_ref((v < 0) ? -1 : 10);
        return s;
    endfunction

    function automatic logic [7*NS-1:0] op_segs(input int a, input int b);
        logic [7*NS-1:0] s;
        int ma, mb;
        s  = '1;
        ma = (a < 0) ? -a : a;
        mb = (b < 0) ? -b : b;
        s[42 +: 7] = seg_ref((a < 0) ? -1 : 10);
        s[35 +: 7] = seg_ref(ma / 10);
        s[28 +: 7] = seg_ref(ma % 10);
        s[14 +: 7] = seg_ref((b < 0) ? -1 : 10);
        s[7 +: 7]  = seg_ref(mb / 10);
        s[0 +: 7]  = seg_ref(mb % 10);
        return s;
    endfunction

    function automatic exp_t model(input int a, input int b, input int op);
        exp_t e;
        if (op == 0) e = '{a + b, 0, 1};
        else if (op == 1) e = '{a - b, 0, 1};
        else if (op == 2) e = '{a * b, 0, MD_LAT};
`ifdef SEQ_CALC_DIV_EN
        else if (b == 0) e = '{0, 1, MD_LAT};
        else e = '{a / b, 0, MD_LAT};
`else
        else e = '{0, 1, 1};
`endif
        return e;
    endfunction

    // Drives start for one edge; returns #1 after the accepting edge.
    task automatic start_op(input int a, input int b, input int op, input exp_t e);
        @(negedge clk);
        bus.a     = W'(a);
        bus.b     = W'(b);
        bus.func  = {1'b0, 2'(op)};
        bus.start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("busy_on_accept", bus.busy, 1);
    endtask

    task automatic wait_done(input string tag);
        int   n;
        exp_t e;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.done && n < 40);
        e = sb.pop_front();
        check({tag, "_done"}, bus.done, 1);
        check({tag, "_out"}, bus.out, e.out);
        check({tag, "_err"}, bus.err, e.err);
        check({tag, "_lat"}, n, e.lat);
        check({tag, "_segs"}, bus.segs, res_segs(e.out));
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, bus.done, 0);
        check({tag, "_idle"}, bus.busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          ra, rb, rop, seen;
        exp_t        e;
        logic [11:0] raw;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.func  = '0;
        #2;
        check("rst_out", bus.out, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_segs", bus.segs, res_segs(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        tbl[0]  = '{-5, 7, 0, 2, 0, 1};
        tbl[1]  = '{-31, 31, 2, -961, 0, MD_LAT};
        tbl[2]  = '{-32, -32, 2, 1024, 0, MD_LAT};
        tbl[3]  = '{10, -20, 1, 30, 0, 1};
        tbl[4]  = '{-32, 31, 1, -63, 0, 1};
        tbl[5]  = '{31, 31, 0, 62, 0, 1};
        tbl[6]  = '{0, -17, 2, 0, 0, MD_LAT};
        tbl[7]  = '{13, -5, 2, -65, 0, MD_LAT};
        tbl[10] = '{4, -9, 0, -5, 0, 1};
`ifdef SEQ_CALC_DIV_EN
        tbl[8]  = '{-20, 3, 3, -6, 0, MD_LAT};
        tbl[9]  = '{9, 0, 3, 0, 1, MD_LAT};
        tbl[11] = '{7, -2, 3, -3, 0, MD_LAT};
        tbl[12] = '{-32, -1, 3, 32, 0, MD_LAT};
`else
        tbl[8]  = '{-20, 3, 3, 0, 1, 1};
        tbl[9]  = '{9, 0, 3, 0, 1, 1};
        tbl[11] = '{7, -2, 3, 0, 1, 1};
        tbl[12] = '{-32, -1, 3, 0, 1, 1};
`endif

        foreach (tbl[i]) begin
            @(negedge clk);
            bus.a    = W'(tbl[i].a);
            bus.b    = W'(tbl[i].b);
            bus.func = 3'b100;
            #1;
            check($sformatf("v%0d_opsegs", i), bus.segs, op_segs(tbl[i].a, tbl[i].b));
            start_op(tbl[i].a, tbl[i].b, tbl[i].op, '{tbl[i].out, tbl[i].err, tbl[i].lat});
            wait_done($sformatf("v%0d", i));
        end

        for (int k = 0; k < 10; k++) begin
            ra  = int'($urandom_range(63)) - 32;
            rb  = int'($urandom_range(63)) - 32;
            rop = int'($urandom_range(3));
            start_op(ra, rb, rop, model(ra, rb, rop));
            wait_done($sformatf("rnd%0d", k));
        end

        // Digit-level display checks on known results.
        start_op(-5, 7, 0, model(-5, 7, 0));
        wait_done("add_disp");
        check("add_hex0", bus.segs[6:0], 7'b0100100);
        check("add_hex4", bus.segs[34:28], 7'b1111111);
        start_op(-31, 31, 2, model(-31, 31, 2));
        wait_done("mul_disp");
        raw = bus.out;
        check("mul_raw", raw, 12'hC3F);
        check("mul_hex4", bus.segs[34:28], 7'b0111111);
        check("mul_hex3", bus.segs[27:21], 7'b1000000);
        check("mul_hex2", bus.segs[20:14], 7'b0010000);

        // A new start clears err on the accepting edge.
        start_op(9, 0, 3, model(9, 0, 3));
        wait_done("dbz");
        start_op(1, 1, 0, model(1, 1, 0));
        check("err_clear", bus.err, 0);
        wait_done("after_dbz");

        // Starts during CALC, including on the completion edge, are ignored.
        start_op(-31, 31, 2, model(-31, 31, 2));
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bus.a     = W'(1);
        bus.b     = W'(1);
        bus.func  = 3'b000;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("mid_busy", bus.busy, 1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("mid_nodone", bus.done, 0);
        bus.a     = W'(2);
        bus.b     = W'(2);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        e = sb.pop_front();
        check("ign_done", bus.done, 1);
        check("ign_out", bus.out, e.out);
        @(posedge clk);
        #1;
        check("ign_pulse", bus.done, 0);
        check("ign_busy", bus.busy, 0);
        check("ign_hold", bus.out, e.out);

        // Reset in HOLD clears err.
        start_op(9, 0, 3, model(9, 0, 3));
        wait_done("dbz2");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_hold_err", bus.err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-multiply: asynchronous clear, no done afterwards.
        start_op(13, -5, 2, model(13, -5, 2));
        wait_done("pre_rst");
        start_op(-31, 31, 2, model(-31, 31, 2));
        sb.delete();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("rst_mid_out", bus.out, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_done", bus.done, 0);
        check("rst_mid_err", bus.err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1;
        end
        check("rst_no_done", seen, 0);
        check("rst_idle", bus.busy, 0);
        start_op(3, 4, 0, model(3, 4, 0));
        wait_done("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
